// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, single-outstanding imem fetch and IF/ID register with stall/redirect handling.
// Optional IF_BUBBLE_CNT_EN adds a saturating count of bubbles loaded into IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, drain_q, drain_d;
  logic [31:0] hold_instr_q, hold_instr_d, hold_pc4_q, hold_pc4_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4, target;
  logic        lost_req;
  assign pc_plus4    = pc_q + 32'd4;
  assign target      = redirect_pc & ~32'd3;
  assign lost_req    = state_q == FETCH && !imem_ready;
  assign imem_req    = !rst && state_q != HOLD;
  assign imem_addr   = state_q == DRAIN ? drain_q : pc_q;
  assign pc          = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_d      = drain_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
      state_d = lost_req || state_q == DRAIN ? DRAIN : FETCH;
      drain_d = lost_req ? pc_q : drain_q;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_plus4;
              state_d      = HOLD;
            end else begin
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = hold_instr_q;
            pc4_d   = hold_pc4_q;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          state_d = imem_ready ? FETCH : DRAIN;
          valid_d = stall ? valid_q : 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_q      <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_q      <= drain_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_q;
  logic        bubble;
  // a bubble is any IF/ID write with valid=0: flush, or an empty cycle decode is not stalling on
  assign bubble     = redirect || (!stall && (lost_req || state_q == DRAIN));
  assign bubble_cnt = bubble_q;
  always_ff @(posedge clk) begin
    if (rst) bubble_q <= '0;
    else if (bubble && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed stimulus against a wait-state memory, with a queue-based fetch model checked every cycle.
module tb_if_fetch_stage;
  logic        clk, rst, imem_req, imem_ready, stall, redirect, if_id_valid, force_rdy;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc, if_id_instr, if_id_pc4;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif
  int checks = 0, errors = 0;
  int waits, wcnt = 0;

  if_fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4)
`ifdef IF_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory answers after 'waits' cycles of a continuously held request
  assign imem_ready = force_rdy || (imem_req && wcnt >= waits);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) wcnt <= (imem_req && !imem_ready) ? wcnt + 1 : 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // model: pending stale request flag, a queue of parked words, and the IF/ID contents
  logic [31:0] m_pc, m_stale, m_instr, m_pc4, m_bub;
  logic        m_v, m_discard, exp_req, resp, bub;
  logic [63:0] park_q[$];
  logic [63:0] w;
  initial begin
    m_pc = 0; m_stale = 0; m_instr = 0; m_pc4 = 0; m_bub = 0; m_v = 0; m_discard = 0;
    forever begin
      @(negedge clk);
      exp_req = !rst && park_q.size() == 0;
      chk("req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("addr", imem_addr, m_discard ? m_stale : m_pc);
      chk("pc", pc, m_pc);
      chk("valid", 32'(if_id_valid), 32'(m_v));
      chk("instr", if_id_instr, m_instr);
      chk("pc4", if_id_pc4, m_pc4);
`ifdef IF_BUBBLE_CNT_EN
      chk("bubble_cnt", bubble_cnt, m_bub);
`endif
      if (rst) begin
        m_pc = 0; m_discard = 0; m_v = 0; m_instr = 0; m_pc4 = 0; m_bub = 0;
        park_q.delete();
      end else begin
        resp = exp_req && imem_ready;
        bub = 0;
        if (redirect) begin
          if (!m_discard && park_q.size() == 0 && !resp) begin
            m_discard = 1;
            m_stale = m_pc;
          end
          park_q.delete();
          m_pc = {redirect_pc[31:2], 2'b00};
          m_v = 0;
          bub = 1;
        end else if (m_discard) begin
          if (resp) m_discard = 0;
          if (!stall) begin m_v = 0; bub = 1; end
        end else if (park_q.size() != 0) begin
          if (!stall) begin {m_instr, m_pc4} = park_q.pop_front(); m_v = 1; end
        end else if (resp) begin
          w = {m_pc ^ 32'hA5A5_0000, m_pc + 32'd4};
          m_pc = m_pc + 32'd4;
          if (stall) park_q.push_back(w);
          else begin {m_instr, m_pc4} = w; m_v = 1; end
        end else if (!stall) begin
          m_v = 0; bub = 1;
        end
        if (bub && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; waits = 0; force_rdy = 0;
    cyc(); cyc();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    rst = 0;
    #1 chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("zw_addr", imem_addr, 32'(4 * (i + 1)));
      chk("zw_instr", if_id_instr, 32'(4 * i) ^ 32'hA5A5_0000);
      chk("zw_pc4", if_id_pc4, 32'(4 * (i + 1)));
      chk("zw_valid", 32'(if_id_valid), 32'd1);
    end
`ifdef IF_BUBBLE_CNT_EN
    chk("zw_bubbles", bubble_cnt, 32'd0);
`endif
    waits = 2;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("w2_valid", 32'(if_id_valid), 32'(i % 3 == 2));
      chk("w2_addr", imem_addr, 32'h10 + 32'(4 * ((i + 1) / 3)));
    end
`ifdef IF_BUBBLE_CNT_EN
    chk("w2_bubbles", bubble_cnt, 32'd4);
`endif
    waits = 0;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_pc4", if_id_pc4, 32'h18);
      chk("hold_valid", 32'(if_id_valid), 32'd1);
    end
    stall = 0;
    cyc();
    chk("release_instr", if_id_instr, 32'hA5A5_0018);
    chk("release_pc4", if_id_pc4, 32'h1C);
    chk("release_addr", imem_addr, 32'h1C);
    cyc();
    chk("after_release_pc4", if_id_pc4, 32'h20);
    stall = 1; redirect = 1; redirect_pc = 32'h0000_0103;
    cyc();
    chk("redir_pc", pc, 32'h100);
    chk("redir_valid", 32'(if_id_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    stall = 0; redirect = 0;
    cyc();
    chk("target_instr", if_id_instr, 32'hA5A5_0100);
    chk("target_pc4", if_id_pc4, 32'h104);
    chk("target_valid", 32'(if_id_valid), 32'd1);
    redirect = 1; redirect_pc = 32'h20;
    cyc();
    redirect = 0; waits = 3;
    cyc();
    redirect = 1; redirect_pc = 32'h200;
    cyc();
    chk("drain_addr", imem_addr, 32'h20);
    chk("drain_pc", pc, 32'h200);
    chk("drain_valid", 32'(if_id_valid), 32'd0);
    redirect = 0;
    cyc();
    chk("drain_addr_stable", imem_addr, 32'h20);
    cyc();
    chk("post_drain_addr", imem_addr, 32'h200);
    chk("post_drain_valid", 32'(if_id_valid), 32'd0);
    repeat (3) cyc();
    chk("w3_still_bubble", 32'(if_id_valid), 32'd0);
    cyc();
    chk("w3_valid", 32'(if_id_valid), 32'd1);
    chk("w3_instr", if_id_instr, 32'hA5A5_0200);
    chk("w3_pc4", if_id_pc4, 32'h204);
    cyc();
    redirect = 1; redirect_pc = 32'h300;
    cyc();
    chk("rd_drain_addr", imem_addr, 32'h204);
    redirect = 0; rst = 1; force_rdy = 1;
    cyc();
    chk("rd_pc", pc, 32'h0);
    chk("rd_valid", 32'(if_id_valid), 32'd0);
    chk("rd_req", 32'(imem_req), 32'd0);
    rst = 0; force_rdy = 0; waits = 0;
    #1 chk("rd_addr", imem_addr, 32'h0);
    cyc();
    chk("rd_instr", if_id_instr, 32'hA5A5_0000);
    chk("rd_first_valid", 32'(if_id_valid), 32'd1);
`ifdef IF_BUBBLE_CNT_EN
    chk("rd_bubbles", bubble_cnt, 32'd0);
`endif
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
